// File: rtl/axi_video_rd_pkg.sv
// Shared types and AXI constants for the video read-burst master.
package axi_video_rd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    WAIT_SPACE,
    ADDR,
    DATA
  } state_e;

  localparam int unsigned AXI_DATA_WIDTH = 256;
  localparam int unsigned BYTES_PER_BEAT = AXI_DATA_WIDTH / 8;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_video_rd_ctrl.sv
// AXI4 read-burst master: fetches a frame from DDR into the video FIFO,
// one burst outstanding, issued only once FIFO space for it is known free.
module axi_video_rd_ctrl
  import axi_video_rd_pkg::*;
#(
  parameter int ADDR_WIDTH       = 28,
  parameter int DATA_WIDTH       = 256,
  parameter int BURST_LEN        = 16,
  parameter int BEATS_WIDTH      = 20,
  parameter int FIFO_DEPTH_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic [ADDR_WIDTH-1:0]       frame_base,
  input  logic [BEATS_WIDTH-1:0]      frame_beats,
  input  logic [FIFO_DEPTH_WIDTH:0]   fifo_wr_level,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_wr_data,
  output logic [ADDR_WIDTH-1:0]       m_araddr,
  output logic [7:0]                  m_arlen,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  input  logic [DATA_WIDTH-1:0]       m_rdata,
  input  logic [1:0]                  m_rresp,
  input  logic                        m_rlast,
  input  logic                        m_rvalid,
  output logic                        m_rready,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        rd_err
);

  localparam int LW         = $clog2(BURST_LEN) + 1;
  localparam int CW         = FIFO_DEPTH_WIDTH + 2;
  localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);

  function automatic logic [LW-1:0] calc_blen(
    input logic [BEATS_WIDTH-1:0] rem
  );
    if (rem >= BEATS_WIDTH'(BURST_LEN))
      return LW'(BURST_LEN);
    return rem[LW-1:0];
  endfunction

  function automatic logic fits(
    input logic [FIFO_DEPTH_WIDTH:0] lvl,
    input logic [LW-1:0]             bl
  );
    logic [CW-1:0] sum;
    sum = CW'(lvl) + CW'(bl);
    return sum <= (CW'(1) << FIFO_DEPTH_WIDTH);
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [BEATS_WIDTH-1:0]  remain_q, remain_d;
  logic [LW-1:0]           blen_q, blen_d;
  logic [LW-1:0]           beat_cnt_q, beat_cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    pend_q, pend_d;
  logic [ADDR_WIDTH-1:0]   pend_base_q, pend_base_d;
  logic [BEATS_WIDTH-1:0]  pend_beats_q, pend_beats_d;

  logic                    beat;
  logic                    last_beat;
  logic [BEATS_WIDTH-1:0]  rem_next;
  logic [ADDR_WIDTH-1:0]   nxt_base;
  logic [BEATS_WIDTH-1:0]  nxt_beats;
  logic                    rlast_unused;

  // The beat counter, not m_rlast, decides where a burst ends.
  assign rlast_unused = m_rlast;

  assign beat      = (state_q == DATA) && m_rvalid;
  assign last_beat = beat && ((beat_cnt_q + 1'b1) == blen_q);

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remain_d     = remain_q;
    blen_d       = blen_q;
    beat_cnt_d   = beat_cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q | (beat && (m_rresp != RESP_OKAY));
    pend_d       = pend_q;
    pend_base_d  = pend_base_q;
    pend_beats_d = pend_beats_q;
    rem_next     = remain_q - BEATS_WIDTH'(blen_q);
    nxt_base     = frame_start ? frame_base : pend_base_q;
    nxt_beats    = frame_start ? frame_beats : pend_beats_q;

    if (frame_start && (state_q != IDLE)) begin
      pend_d       = 1'b1;
      pend_base_d  = frame_base;
      pend_beats_d = frame_beats;
    end

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          cur_addr_d = frame_base;
          remain_d   = frame_beats;
          if (frame_beats == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = SETTLE;
          end
        end
      end
      SETTLE: state_d = WAIT_SPACE;
      WAIT_SPACE: begin
        if (fits(fifo_wr_level, calc_blen(remain_q))) begin
          blen_d  = calc_blen(remain_q);
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (m_arready) begin
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (beat)
          beat_cnt_d = beat_cnt_q + 1'b1;
        if (last_beat) begin
          if (pend_q || frame_start) begin
            // Abandon the current frame silently and refetch.
            pend_d     = 1'b0;
            cur_addr_d = nxt_base;
            remain_d   = nxt_beats;
            if (nxt_beats == '0) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              state_d = SETTLE;
            end
          end else begin
            cur_addr_d = cur_addr_q +
                         (ADDR_WIDTH'(blen_q) << BEAT_SHIFT);
            remain_d   = rem_next;
            if (rem_next == '0) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              state_d = SETTLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      remain_q     <= '0;
      blen_q       <= '0;
      beat_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      pend_q       <= 1'b0;
      pend_base_q  <= '0;
      pend_beats_q <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      remain_q     <= remain_d;
      blen_q       <= blen_d;
      beat_cnt_q   <= beat_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      pend_q       <= pend_d;
      pend_base_q  <= pend_base_d;
      pend_beats_q <= pend_beats_d;
    end
  end

  assign m_arvalid    = (state_q == ADDR);
  assign m_araddr     = cur_addr_q;
  assign m_arlen      = (state_q == ADDR) ? 8'(blen_q - 1'b1) : 8'd0;
  assign m_rready     = (state_q == DATA);
  assign fifo_wr_en   = beat;
  assign fifo_wr_data = m_rdata;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign rd_err       = err_q;

endmodule
